chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder (a + b + cin) that processes CHUNK bits per clock through a ripple of
//  1-bit full-adder slices, with the carry registered between chunks. Next generation of the fixed
//  8-bit ripple adder: parametrised width and chunk size, plus valid/ready handshakes on input and
//  output. Sits in the arithmetic datapath wherever a wide add can trade latency for area.
// PARAMETERS
//  WIDTH  32  operand/sum width in bits; must be a multiple of CHUNK
//  CHUNK   8  bits added per BUSY cycle; 1 <= CHUNK <= WIDTH
//  (derived) NCHUNK = WIDTH/CHUNK = latency in BUSY cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand A (unsigned or two's complement)
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry in
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  sum[WIDTH-1:0]
//  out_cout   out  1      carry out of bit WIDTH-1
//  out_ovf    out  1      signed overflow (present only with ADDER_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0,
//    chunk counter=0, carry reg=0. Reset mid-operation discards the operation; nothing is output.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&&in_ready at edge E0 -> latch a, b, cin into carry reg; go BUSY, cnt=0.
//    BUSY: in_ready=0. Each edge adds chunk cnt (bits cnt*CHUNK+:CHUNK) of a and b plus carry reg,
//      writes that sum chunk, stores chunk carry-out in carry reg, cnt++. At edge E(NCHUNK)
//      (last chunk) -> DONE, out_cout = final carry.
//    DONE: out_valid=1, out_sum/out_cout/out_ovf stable. out_ready=1 at an edge -> IDLE, out_valid=0.
//      out_ready low: hold indefinitely, in_ready stays 0 (no accept while result pending).
//  - Latency: out_valid rises NCHUNK cycles after acceptance edge. Throughput: one op per NCHUNK+2
//    cycles at best (accept, NCHUNK busy, handshake).
//  - in_a/in_b/in_cin sampled only at acceptance; changes during BUSY/DONE ignored.
//  - in_valid and out_ready may be asserted together; only the current state's handshake applies.
//  - Arithmetic modulo 2^WIDTH; {out_cout,out_sum} = a + b + cin exactly (WIDTH+1 bits).
//  - out_sum/out_cout/out_ovf meaningful only while out_valid=1; they hold their last values after
//    the output handshake until the next result is written during BUSY.
//  - CHUNK==WIDTH: single BUSY cycle; NCHUNK==1 counter of width 1 still legal.
// CONFIGURATION
//  ADDER_OVF_EN defined: out_ovf port exists; out_ovf = carry into MSB XOR carry out of MSB, captured
//    on the last BUSY edge, reset 0.
//  ADDER_OVF_EN undefined: out_ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package adder_pkg: FSM state typedef (IDLE, BUSY, DONE); function clog2-based counter
//    width for NCHUNK; parameter legality check (WIDTH % CHUNK == 0).
//  - Sub-module chunk_ripple_adder #(CHUNK): CHUNK chained 1-bit full-adder slices; ports a, b, cin,
//    sum, cout, msb_cin (msb_cin used for overflow). One instance; top holds FSM, counter, operand and
//    sum registers.
// TESTING
//  1 WIDTH=32,CHUNK=8: a=10,b=5,cin=0 -> out_sum=15, out_cout=0, out_valid exactly 4 cycles after accept.
//  2 a=0xFFFFFFFF,b=0,cin=1 -> out_sum=0, out_cout=1 (carry ripples through all 4 chunk registers).
//  3 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_sum stable, in_ready=0;
//    a new in_valid during that time is not accepted.
//  4 Assert rst_n=0 during BUSY at cnt=2 -> out_valid=0, in_ready=1 immediately; next op 0x10+0x20=0x30.
//  5 ADDER_OVF_EN: a=0x7FFFFFFF,b=1 -> out_ovf=1, out_cout=0; a=0xFFFFFFFF,b=1 -> out_ovf=0, out_cout=1.
//  6 WIDTH=8,CHUNK=1: 15+15,cin=0 -> out_sum=30, latency 8; back-to-back ops with out_ready=1 tied.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Optional signed-overflow output is enabled with the ADDER_OVF_EN macro.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The chunk counter needs at least one bit even when a single chunk covers the word.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// CHUNK-bit ripple of 1-bit full-adder slices; msb_cin is the carry into the top slice.
module chunk_ripple_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_slice
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout    = c[CHUNK];
    assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per cycle, with valid/ready on both sides.
// Define ADDER_OVF_EN to add the out_ovf signed-overflow output.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is 1 only in IDLE; out_valid is 1 only in DONE and holds until out_ready.
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_shift, b_shift, sum_next;
    logic [CHUNK-1:0] sum_chunk;
    logic             chunk_cout, msb_cin;

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
        .a       (a_q[CHUNK-1:0]),
        .b       (b_q[CHUNK-1:0]),
        .cin     (carry),
        .sum     (sum_chunk),
        .cout    (chunk_cout),
        .msb_cin (msb_cin)
    );

    // Operands shift down so the active chunk is always the low slice; sum chunks enter from the top.
    if (NCHUNK == 1) begin : g_single
        assign a_shift  = '0;
        assign b_shift  = '0;
        assign sum_next = sum_chunk;
    end else begin : g_multi
        assign a_shift  = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_shift  = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        assign sum_next = {sum_chunk, out_sum[WIDTH-1:CHUNK]};
    end

`ifndef ADDER_OVF_EN
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef ADDER_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        carry    <= in_cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_shift;
                    b_q     <= b_shift;
                    carry   <= chunk_cout;
                    out_sum <= sum_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_cout  <= chunk_cout;
`ifdef ADDER_OVF_EN
                        out_ovf   <= msb_cin ^ chunk_cout;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: 32/8 instance for vectors and corner cases, 8/1 instance for bit-serial.
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 32-bit, 8-bit chunk instance
    logic        in_valid = 1'b0, in_ready, in_cin = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, out_sum;
    logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;

    // 8-bit, 1-bit chunk instance, output side always ready
    logic        in_valid8 = 1'b0, in_ready8, in_cin8 = 1'b0;
    logic [7:0]  in_a8 = '0, in_b8 = '0, out_sum8;
    logic        out_valid8, out_cout8, out_ovf8;
    logic        out_ready8;
    assign out_ready8 = 1'b1;

    chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDER_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_cout(out_cout8)
`ifdef ADDER_OVF_EN
        , .out_ovf(out_ovf8)
`endif
    );

`ifndef ADDER_OVF_EN
    assign out_ovf  = 1'b0;
    assign out_ovf8 = 1'b0;
`endif

    // Expected {ovf, cout, sum} and {cout, sum}
    logic [33:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard: results leave on an edge where out_valid && out_ready; sample before that edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_result32");
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("sum32", 64'(out_sum), 64'(e[31:0]));
                check("cout32", 64'(out_cout), 64'(e[32]));
`ifdef ADDER_OVF_EN
                check("ovf32", 64'(out_ovf), 64'(e[33]));
`endif
            end
        end
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                timeout("unexpected_result8");
            end else begin
                logic [8:0] e8;
                e8 = exp8_q.pop_front();
                check("sum8", 64'(out_sum8), 64'(e8[7:0]));
                check("cout8", 64'(out_cout8), 64'(e8[8]));
            end
        end
    end

    // Drive one op into the 32-bit instance; lat = edges from acceptance to out_valid.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [33:0] exp, output int lat);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) timeout("accept32");
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) timeout("result32");
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, output int lat);
        int n;
        in_a8 = a; in_b8 = b; in_cin8 = cin; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready8) timeout("accept8");
        exp8_q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid8) timeout("result8");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held;
        logic [31:0] ra, rb, rs;
        logic        rc, rco;

        vecs[0] = '{32'd10,        32'd5,         1'b0, 32'd15,        1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF,  32'h0,         1'b1, 32'h0,         1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF,  32'h1,         1'b0, 32'h80000000,  1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF,  32'h1,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
        vecs[5] = '{32'h12345678,  32'h87654321,  1'b0, 32'h99999999,  1'b0, 1'b0};
        vecs[6] = '{32'h000000FF,  32'h00000001,  1'b0, 32'h00000100,  1'b0, 1'b0};
        vecs[7] = '{32'h80000000,  32'h80000000,  1'b0, 32'h0,         1'b1, 1'b1};

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors, each with latency of 4 cycles
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, lat);
            check($sformatf("latency32_%0d", i), 64'(lat), 64'd4);
            @(posedge clk); #1;
        end

        // Random operands against a 33-bit reference add
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            send(ra, rb, rc, {(ra[31] == rb[31]) && (rs[31] != ra[31]), rco, rs}, lat);
        end
        @(posedge clk); #1;

        // Backpressure: result held for 5 cycles, no new acceptance
        out_ready = 1'b0;
        send(32'h00001234, 32'h00004321, 1'b1, {1'b0, 1'b0, 32'h00005556}, lat);
        held = out_sum;
        check("bp_held_value", 64'(held), 64'h5556);
        in_a = 32'hDEAD0000; in_b = 32'h0000BEEF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum_stable", 64'(out_sum), 64'(held));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        check("bp_nothing_extra", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check("bp_no_late_accept", 64'(in_ready), 64'd1);

        // Reset during BUSY at cnt=2 discards the op
        in_a = 32'hAAAA5555; in_b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_busy_not_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_sum", 64'(out_sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_output", 64'(out_valid), 64'd0);
        end
        send(32'h10, 32'h20, 1'b0, {1'b0, 1'b0, 32'h30}, lat);
        check("after_rst_latency", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // Bit-serial instance: latency 8, then back-to-back ops
        send8(8'd15, 8'd15, 1'b0, lat);
        check("latency8", 64'(lat), 64'd8);
        check("sum8_direct", 64'(out_sum8), 64'd30);
        send8(8'hFF, 8'h00, 1'b1, lat);
        check("latency8_carry", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), lat);
        end

        repeat (4) @(posedge clk);
        #1;
        check("drain32", 64'(exp_q.size()), 64'd0);
        check("drain8", 64'(exp8_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
